// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: 68000 bus-cycle controller for the NeoGeo.
// It generates nDTACK with per-region wait states and an external-ready stall,
// and nBERR when a cycle times out. It latches interrupt sources, drives them
// onto IPL and answers IACK cycles with an autovector (nVPA).
module m68k_bus_ctrl #(
   parameter int unsigned     ADDR_W    = 23,
   parameter int unsigned     NUM_IRQ   = 3,
   parameter int unsigned     WS_W      = 3,
   parameter logic [WS_W-1:0] WAIT_FAST = '0,
   parameter int unsigned     TIMEOUT   = 64
) (
   input  logic               CLK_68KCLK,
   input  logic               RESET,
   input  logic               nAS,
   input  logic               nUDS,
   input  logic               nLDS,
   input  logic               M68K_RW,
   input  logic [ADDR_W:1]    M68K_ADDR,
   input  logic [2:0]         FC,
   input  logic               SLOW_SEL,
   input  logic [WS_W-1:0]    WAIT_SLOW,
   input  logic               EXT_READY,
   input  logic [NUM_IRQ-1:0] IRQ_REQ,
   output logic [2:0]         IPL,
   output logic               nDTACK,
   output logic               nVPA,
   output logic               nBERR,
   output logic [NUM_IRQ-1:0] IRQ_ACK
);

   localparam int unsigned TC_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_ERR
   } state_t;

   state_t             state, state_nx;
   logic [WS_W-1:0]    wcnt, wcnt_nx;
   logic [TC_W-1:0]    tcnt, tcnt_nx;
   logic               dtack_nx, vpa_nx, berr_nx;
   logic [NUM_IRQ-1:0] ack_nx;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [2:0]         ipl_nx;

   // Data strobes, direction and upper address bits are only observed, never decoded here.
   logic unused_ok;
   assign unused_ok = ^{nUDS, nLDS, M68K_RW, M68K_ADDR[ADDR_W:4]};

   // Bus-cycle state register and registered strobes.
   always_ff @(posedge CLK_68KCLK) begin
      if (RESET) begin
         state  <= S_IDLE;
         wcnt   <= '0;
         tcnt   <= '0;
         nDTACK <= 1'b1;
         nVPA   <= 1'b1;
         nBERR  <= 1'b1;
      end else begin
         state  <= state_nx;
         wcnt   <= wcnt_nx;
         tcnt   <= tcnt_nx;
         nDTACK <= dtack_nx;
         nVPA   <= vpa_nx;
         nBERR  <= berr_nx;
      end
   end

   // Next-state, counters and next strobe values; the ACK/ERR strobe is computed
   // on the same edge the transition is taken so the output is registered.
   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      tcnt_nx  = tcnt;
      dtack_nx = nDTACK;
      vpa_nx   = nVPA;
      berr_nx  = nBERR;
      ack_nx   = '0;
      unique case (state)
         S_IDLE: begin
            dtack_nx = 1'b1;
            vpa_nx   = 1'b1;
            berr_nx  = 1'b1;
            if (!nAS) begin
               wcnt_nx = SLOW_SEL ? WAIT_SLOW : WAIT_FAST;
               tcnt_nx = '0;
               if (FC == 3'b111) begin
                  state_nx = S_ACK;
                  vpa_nx   = 1'b0;
                  for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                     if (M68K_ADDR[3:1] == 3'(i + 1)) ack_nx[i] = 1'b1;
                  end
               end else if (wcnt_nx == '0 && EXT_READY) begin
                  state_nx = S_ACK;
                  dtack_nx = 1'b0;
               end else begin
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (nAS) begin
               state_nx = S_IDLE;
            end else begin
               tcnt_nx = tcnt + 1'b1;
               if (wcnt != '0) wcnt_nx = wcnt - 1'b1;
               // Ready is judged on the post-decrement count so N wait states give N+1 edges of latency.
               if (tcnt_nx == TC_W'(TIMEOUT)) begin
                  state_nx = S_ERR;
                  berr_nx  = 1'b0;
               end else if (wcnt_nx == '0 && EXT_READY) begin
                  state_nx = S_ACK;
                  dtack_nx = 1'b0;
               end
            end
         end
         S_ACK, S_ERR: begin
            if (nAS) begin
               state_nx = S_IDLE;
               dtack_nx = 1'b1;
               vpa_nx   = 1'b1;
               berr_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Priority encoder: highest pending source i gives level i+1, inverted.
   always_comb begin
      ipl_nx = 3'b111;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (pending[i]) ipl_nx = ~3'(i + 1);
      end
   end

   // Interrupt latching: a rising edge sets pending and beats an IACK clear on the same edge.
   always_ff @(posedge CLK_68KCLK) begin
      if (RESET) begin
         pending  <= '0;
         irq_prev <= IRQ_REQ;
         IRQ_ACK  <= '0;
         IPL      <= 3'b111;
      end else begin
         pending  <= (pending & ~ack_nx) | (IRQ_REQ & ~irq_prev);
         irq_prev <= IRQ_REQ;
         IRQ_ACK  <= ack_nx;
         IPL      <= ipl_nx;
      end
   end

endmodule
